// File: rtl/ctech_clk_gate_ctrl.sv
// ctech_clk_gate_ctrl
// Idle-hysteresis controller for a clock-gate cell. It watches the requesters,
// the downstream busy flag and the force-run control, closes the gate after a
// programmable run of idle cycles, reopens it on new activity, and only grants
// requesters once the gated clock has been running for WAKE_LAT cycles.
// Lives in the ungated clock domain next to the gate cell.

module ctech_clk_gate_ctrl #(
    parameter int NUM_REQ  = 4,
    parameter int HYST_W   = 8,
    parameter int WAKE_LAT = 2,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               busy,
    input  logic [HYST_W-1:0]  hyst_cfg,
    input  logic               cg_disable,
    input  logic               test_mode,
    output logic               cg_en,
    output logic               cg_te,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gated,
    output logic [CNT_W-1:0]   gate_events
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_IDLE = 2'd1,
        ST_OFF  = 2'd2,
        ST_WAKE = 2'd3
    } state_t;

    // Wake counter is sized for the largest supported WAKE_LAT (15).
    localparam logic [3:0] WAKE_LOAD = 4'(WAKE_LAT - 1);

    state_t              state_q;
    state_t              state_d;
    logic [HYST_W-1:0]   idle_cnt_q;
    logic [HYST_W-1:0]   idle_cnt_d;
    logic [3:0]          wake_cnt_q;
    logic [3:0]          wake_cnt_d;
    logic                act;
    logic [HYST_W-1:0]   hyst_eff;
    logic [HYST_W-1:0]   idle_load;
    logic                enter_off;
    logic [NUM_REQ-1:0]  gnt_d;

    // Any requester, downstream busy or the force-run control keeps the clock alive.
    always_comb begin
        act = (|req) | busy | cg_disable;
    end

    // Hysteresis length, with 0 treated as 1; the loaded count is the number
    // of further idle samples still needed after the one that left RUN.
    always_comb begin
        hyst_eff  = (hyst_cfg == '0) ? HYST_W'(1) : hyst_cfg;
        idle_load = hyst_eff - HYST_W'(1);
    end

    // Next-state and counter-update logic for the RUN/IDLE/OFF/WAKE machine.
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        wake_cnt_d = wake_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (!act) begin
                    if (idle_load == '0) begin
                        state_d    = ST_OFF;
                        idle_cnt_d = '0;
                    end else begin
                        state_d    = ST_IDLE;
                        idle_cnt_d = idle_load;
                    end
                end
            end
            ST_IDLE: begin
                // The idle counter holds how many idle samples are still owed;
                // consuming the last one closes the gate on this very edge.
                if (act) begin
                    state_d    = ST_RUN;
                    idle_cnt_d = '0;
                end else if (idle_cnt_q <= HYST_W'(1)) begin
                    state_d    = ST_OFF;
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q - HYST_W'(1);
                end
            end
            ST_OFF: begin
                if (act) begin
                    state_d    = ST_WAKE;
                    wake_cnt_d = WAKE_LOAD;
                end
            end
            ST_WAKE: begin
                // Wake-up always runs to completion so the clock is known to
                // be stable before any grant is issued.
                if (wake_cnt_q == 4'd0) begin
                    state_d = ST_RUN;
                end else begin
                    wake_cnt_d = wake_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d    = ST_RUN;
                idle_cnt_d = '0;
                wake_cnt_d = '0;
            end
        endcase
    end

    // A gate event is any edge that moves from a running state into OFF.
    always_comb begin
        enter_off = (state_d == ST_OFF) && (state_q != ST_OFF);
    end

    // Grants follow the requests only when the machine will be in RUN, which
    // keeps them aligned with the registered state.
    always_comb begin
        gnt_d = (state_d == ST_RUN) ? req : '0;
    end

    // State and hysteresis/wake counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            idle_cnt_q <= '0;
            wake_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            wake_cnt_q <= wake_cnt_d;
        end
    end

    // Registered gate-cell enable, gated flag and grants, decoded from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            cg_en <= 1'b1;
            gated <= 1'b0;
            gnt   <= '0;
        end else begin
            cg_en <= (state_d != ST_OFF);
            gated <= (state_d == ST_OFF);
            gnt   <= gnt_d;
        end
    end

    // Saturating count of entries into OFF.
    always_ff @(posedge clk) begin
        if (rst) begin
            gate_events <= '0;
        end else if (enter_off && (gate_events != '1)) begin
            gate_events <= gate_events + CNT_W'(1);
        end
    end

    // Test enable bypasses the state machine entirely so scan clocking never
    // depends on the idle/wake sequence.
    always_comb begin
        cg_te = test_mode;
    end

endmodule
